// File: rtl/pal_sync_generator_multimode.sv
// rtl/pal_sync_generator_multimode.sv - PAL raster/sync generator for 48K, 128K and Pentagon timings
// Mode requests are latched only at the frame boundary so the raster never glitches.
module pal_sync_generator_multimode #(
   parameter int CW      = 3,
   parameter int HW      = 9,
   parameter int VW      = 9,
   parameter int INT_LEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode,
   input  logic [CW-1:0] ri,
   input  logic [CW-1:0] gi,
   input  logic [CW-1:0] bi,
   output logic [HW-1:0] hcnt,
   output logic [VW-1:0] vcnt,
   output logic [CW-1:0] ro,
   output logic [CW-1:0] go,
   output logic [CW-1:0] bo,
   output logic          hsync,
   output logic          vsync,
   output logic          csync,
   output logic          int_n,
   output logic          frame_start,
   output logic [1:0]    active_mode
);

   localparam logic [HW-1:0] HB_START = HW'(320);
   localparam logic [HW-1:0] HB_END   = HW'(415);
   localparam logic [HW-1:0] HS_START = HW'(344);
   localparam logic [HW-1:0] HS_END   = HW'(375);
   localparam logic [VW-1:0] VB_END   = VW'(255);
   localparam logic [31:0]   INT_LEN_U = 32'(INT_LEN);

   logic [HW-1:0] hc_q, hc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic [1:0]    mode_q, mode_d;
   logic [CW-1:0] ro_q, ro_d, go_q, go_d, bo_q, bo_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
   logic          int_n_q, int_n_d, fs_q, fs_d;

   logic [HW-1:0] hend;
   logic [VW-1:0] vend;
   logic [VW-1:0] vb_start;
   logic          h_last, v_last;
   logic          hblank, vblank, blank, hs_win, vs_win;

   // Reserved mode 11 decodes as 48K.
   always_comb begin
      hend     = HW'(447);
      vend     = VW'(311);
      vb_start = VW'(248);
      case (mode_q)
         2'b01: begin
            hend = HW'(455);
            vend = VW'(310);
         end
         2'b10: begin
            vend     = VW'(319);
            vb_start = VW'(240);
         end
         default: ;
      endcase
   end

   // Using >= lets a counter beyond its end wrap on the next step instead of running away.
   always_comb begin
      h_last = (hc_q >= hend);
      v_last = (vc_q >= vend);
      hc_d   = h_last ? '0 : hc_q + HW'(1);
      vc_d   = vc_q;
      if (h_last) begin
         vc_d = v_last ? '0 : vc_q + VW'(1);
      end
      mode_d = (h_last && v_last) ? mode : mode_q;
   end

   always_comb begin
      hblank  = (hc_q >= HB_START) && (hc_q <= HB_END);
      hs_win  = (hc_q >= HS_START) && (hc_q <= HS_END);
      vblank  = (vc_q >= vb_start) && (vc_q <= VB_END);
      vs_win  = (vc_q >= vb_start) && (vc_q <= vb_start + VW'(3));
      blank   = hblank || vblank;
      ro_d    = blank ? '0 : ri;
      go_d    = blank ? '0 : gi;
      bo_d    = blank ? '0 : bi;
      hsync_d = ~(hs_win && blank);
      vsync_d = ~(vs_win && blank);
      csync_d = hsync_d && vsync_d;
      int_n_d = ~((vc_q == vb_start) && (32'(hc_q) < INT_LEN_U));
      fs_d    = (hc_q == '0) && (vc_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_q    <= '0;
         vc_q    <= '0;
         mode_q  <= 2'b00;
         ro_q    <= '0;
         go_q    <= '0;
         bo_q    <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         csync_q <= 1'b1;
         int_n_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         mode_q  <= mode_d;
         ro_q    <= ro_d;
         go_q    <= go_d;
         bo_q    <= bo_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         csync_q <= csync_d;
         int_n_q <= int_n_d;
         fs_q    <= fs_d;
      end
   end

   assign hcnt        = hc_q;
   assign vcnt        = vc_q;
   assign ro          = ro_q;
   assign go          = go_q;
   assign bo          = bo_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign csync       = csync_q;
   assign int_n       = int_n_q;
   assign frame_start = fs_q;
   assign active_mode = mode_q;

endmodule

// File: tb/tb_pal_sync_generator_multimode.sv
// tb/tb_pal_sync_generator_multimode.sv - directed table-driven bench for the multimode PAL sync generator
// Raster positions are preloaded into the counters so far-away lines are reached without running whole frames.
module tb_pal_sync_generator_multimode;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [2:0] ri, gi, bi;
   logic [8:0] hcnt, vcnt;
   logic [2:0] ro, go, bo;
   logic       hsync, vsync, csync, int_n, frame_start;
   logic [1:0] active_mode;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0] m;
      logic [8:0] h, v;
      logic [2:0] c;
      logic       eblank, ehs, evs, eint;
      logic [8:0] ehn, evn;
   } vec_t;

   vec_t tbl[$];
   logic [1:0] cur;

   pal_sync_generator_multimode dut (
      .clk(clk), .rst(rst), .mode(mode),
      .ri(ri), .gi(gi), .bi(bi),
      .hcnt(hcnt), .vcnt(vcnt),
      .ro(ro), .go(go), .bo(bo),
      .hsync(hsync), .vsync(vsync), .csync(csync),
      .int_n(int_n), .frame_start(frame_start),
      .active_mode(active_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] hend_of(input logic [1:0] m);
      return (m == 2'b01) ? 9'd455 : 9'd447;
   endfunction

   function automatic logic [8:0] vend_of(input logic [1:0] m);
      return (m == 2'b01) ? 9'd310 : (m == 2'b10) ? 9'd319 : 9'd311;
   endfunction

   task automatic goto_pos(input logic [8:0] h, input logic [8:0] v);
      @(negedge clk);
      force dut.hc_q = h;
      force dut.vc_q = v;
      #1;
      release dut.hc_q;
      release dut.vc_q;
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic switch_mode(input logic [1:0] nm);
      mode = nm;
      goto_pos(hend_of(cur), vend_of(cur));
      step();
      chk("switch_active_mode", 32'(active_mode), 32'(nm));
      chk("switch_hcnt", 32'(hcnt), 0);
      chk("switch_vcnt", 32'(vcnt), 0);
      cur = nm;
      step();
      chk("switch_frame_start", 32'(frame_start), 1);
   endtask

   task automatic add(input logic [1:0] m, input int h, input int v, input logic [2:0] c,
                      input logic eb, input logic hs, input logic vs, input logic it,
                      input int hn, input int vn);
      vec_t e;
      e.m = m; e.h = 9'(h); e.v = 9'(v); e.c = c;
      e.eblank = eb; e.ehs = hs; e.evs = vs; e.eint = it;
      e.ehn = 9'(hn); e.evn = 9'(vn);
      tbl.push_back(e);
   endtask

   initial begin
      int hs_low, ro_zero, fs_cnt, int_low;
      logic [2:0] exp_c;

      // 48K
      add(0, 319,   0, 7, 0, 1, 1, 1, 320,   0);
      add(0, 320,   0, 7, 1, 1, 1, 1, 321,   0);
      add(0, 343,  10, 5, 1, 1, 1, 1, 344,  10);
      add(0, 344,  10, 5, 1, 0, 1, 1, 345,  10);
      add(0, 375,  10, 6, 1, 0, 1, 1, 376,  10);
      add(0, 376,  10, 6, 1, 1, 1, 1, 377,  10);
      add(0, 415,  10, 3, 1, 1, 1, 1, 416,  10);
      add(0, 416,  10, 3, 0, 1, 1, 1, 417,  10);
      add(0, 447,   5, 7, 0, 1, 1, 1,   0,   6);
      add(0, 447, 311, 7, 0, 1, 1, 1,   0,   0);
      add(0,   0,   0, 7, 0, 1, 1, 1,   1,   0);
      add(0, 100, 247, 7, 0, 1, 1, 1, 101, 247);
      add(0, 100, 248, 7, 1, 1, 0, 1, 101, 248);
      add(0,  31, 248, 7, 1, 1, 0, 0,  32, 248);
      add(0,  32, 248, 7, 1, 1, 0, 1,  33, 248);
      add(0,   0, 248, 7, 1, 1, 0, 0,   1, 248);
      add(0, 100, 251, 7, 1, 1, 0, 1, 101, 251);
      add(0, 100, 252, 7, 1, 1, 1, 1, 101, 252);
      add(0, 360, 250, 7, 1, 0, 0, 1, 361, 250);
      add(0, 100, 255, 7, 1, 1, 1, 1, 101, 255);
      add(0, 100, 256, 7, 0, 1, 1, 1, 101, 256);
      add(0, 100, 240, 7, 0, 1, 1, 1, 101, 240);
      add(0, 460, 315, 7, 0, 1, 1, 1,   0,   0);
      // 128K
      add(1, 447, 100, 7, 0, 1, 1, 1, 448, 100);
      add(1, 455, 100, 7, 0, 1, 1, 1,   0, 101);
      add(1, 455, 310, 7, 0, 1, 1, 1,   0,   0);
      add(1,  31, 248, 7, 1, 1, 0, 0,  32, 248);
      add(1, 100, 249, 7, 1, 1, 0, 1, 101, 249);
      add(1, 360, 100, 4, 1, 0, 1, 1, 361, 100);
      // Pentagon
      add(2, 447, 100, 7, 0, 1, 1, 1,   0, 101);
      add(2, 447, 310, 7, 0, 1, 1, 1,   0, 311);
      add(2, 100, 239, 7, 0, 1, 1, 1, 101, 239);
      add(2, 100, 240, 7, 1, 1, 0, 1, 101, 240);
      add(2,  31, 240, 7, 1, 1, 0, 0,  32, 240);
      add(2, 100, 243, 7, 1, 1, 0, 1, 101, 243);
      add(2, 100, 244, 7, 1, 1, 1, 1, 101, 244);
      add(2,  31, 248, 7, 1, 1, 1, 1,  32, 248);
      add(2, 447, 319, 7, 0, 1, 1, 1,   0,   0);
      // Reserved behaves as 48K
      add(3, 447, 100, 7, 0, 1, 1, 1,   0, 101);
      add(3, 455,  10, 7, 0, 1, 1, 1,   0,  11);
      add(3,   5, 248, 7, 1, 1, 0, 0,   6, 248);
      add(3, 100, 240, 7, 0, 1, 1, 1, 101, 240);
      add(3, 447, 311, 7, 0, 1, 1, 1,   0,   0);

      rst = 1'b1; mode = 2'b00; ri = 3'd7; gi = 3'd6; bi = 3'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_hcnt", 32'(hcnt), 0);
      chk("reset_vcnt", 32'(vcnt), 0);
      chk("reset_ro", 32'(ro), 0);
      chk("reset_hsync", 32'(hsync), 1);
      chk("reset_vsync", 32'(vsync), 1);
      chk("reset_csync", 32'(csync), 1);
      chk("reset_int_n", 32'(int_n), 1);
      chk("reset_frame_start", 32'(frame_start), 0);
      chk("reset_active_mode", 32'(active_mode), 0);
      cur = 2'b00;

      // Natural first line: 448 output samples covering hc 0..447 on line 0
      rst = 1'b0;
      hs_low = 0; ro_zero = 0; fs_cnt = 0; int_low = 0;
      for (int i = 0; i < 448; i++) begin
         step();
         if (i == 0) chk("first_hcnt", 32'(hcnt), 1);
         if (!hsync) hs_low++;
         if (ro == 3'd0) ro_zero++;
         if (frame_start) fs_cnt++;
         if (!int_n) int_low++;
         if (!csync != (!hsync || !vsync)) chk("line0_csync", 32'(csync), 32'(hsync & vsync));
      end
      chk("line0_hsync_low", 32'(hs_low), 32);
      chk("line0_blank", 32'(ro_zero), 96);
      chk("line0_frame_start", 32'(fs_cnt), 1);
      chk("line0_int_low", 32'(int_low), 0);
      chk("line1_hcnt", 32'(hcnt), 0);
      chk("line1_vcnt", 32'(vcnt), 1);

      // Mid-frame toggling must not change the mode in effect
      for (int k = 0; k < 6; k++) begin
         mode = 2'(k % 2 == 0 ? 1 : 0);
         repeat (37) @(negedge clk);
         chk($sformatf("toggle_%0d_active", k), 32'(active_mode), 0);
      end
      mode = 2'b01;
      goto_pos(9'd200, 9'd311);
      step();
      chk("toggle_lastline_active", 32'(active_mode), 0);
      mode = 2'b00;
      goto_pos(9'd447, 9'd311);
      step();
      chk("toggle_boundary_active", 32'(active_mode), 0);
      goto_pos(9'd447, 9'd100);
      step();
      chk("toggle_48k_wrap", 32'(hcnt), 0);

      foreach (tbl[i]) begin
         if (tbl[i].m != cur) switch_mode(tbl[i].m);
         mode = cur;
         ri = tbl[i].c; gi = tbl[i].c ^ 3'd1; bi = tbl[i].c;
         goto_pos(tbl[i].h, tbl[i].v);
         step();
         exp_c = tbl[i].eblank ? 3'd0 : tbl[i].c;
         chk($sformatf("v%0d_ro", i), 32'(ro), 32'(exp_c));
         chk($sformatf("v%0d_go", i), 32'(go), 32'(tbl[i].eblank ? 3'd0 : (tbl[i].c ^ 3'd1)));
         chk($sformatf("v%0d_hsync", i), 32'(hsync), 32'(tbl[i].ehs));
         chk($sformatf("v%0d_vsync", i), 32'(vsync), 32'(tbl[i].evs));
         chk($sformatf("v%0d_csync", i), 32'(csync), 32'(tbl[i].ehs & tbl[i].evs));
         chk($sformatf("v%0d_int_n", i), 32'(int_n), 32'(tbl[i].eint));
         chk($sformatf("v%0d_frame_start", i), 32'(frame_start),
             32'(tbl[i].h == 9'd0 && tbl[i].v == 9'd0));
         chk($sformatf("v%0d_hcnt", i), 32'(hcnt), 32'(tbl[i].ehn));
         chk($sformatf("v%0d_vcnt", i), 32'(vcnt), 32'(tbl[i].evn));
         chk($sformatf("v%0d_active", i), 32'(active_mode), 32'(tbl[i].m));
      end

      // Asynchronous reset in the middle of a sync pulse
      goto_pos(9'd350, 9'd248);
      step();
      chk("pre_reset_hsync", 32'(hsync), 0);
      chk("pre_reset_vsync", 32'(vsync), 0);
      #2 rst = 1'b1;
      #1;
      chk("async_hcnt", 32'(hcnt), 0);
      chk("async_vcnt", 32'(vcnt), 0);
      chk("async_hsync", 32'(hsync), 1);
      chk("async_vsync", 32'(vsync), 1);
      chk("async_csync", 32'(csync), 1);
      chk("async_int_n", 32'(int_n), 1);
      chk("async_active_mode", 32'(active_mode), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cur = 2'b00;
      mode = 2'b11;
      step();
      chk("post_reset_hcnt", 32'(hcnt), 1);
      chk("post_reset_vcnt", 32'(vcnt), 0);
      chk("post_reset_frame_start", 32'(frame_start), 1);
      chk("post_reset_active", 32'(active_mode), 0);
      goto_pos(9'd447, 9'd100);
      step();
      chk("post_reset_48k_wrap_h", 32'(hcnt), 0);
      chk("post_reset_48k_wrap_v", 32'(vcnt), 101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pal_sync_generator_multimode.md
Name: pal_sync_generator_multimode

Overview:
- Parametrised successor to the fixed two-mode Sinclair PAL sync generator.
- Drives the raster counters, blanking, H/V/composite sync and the CPU frame interrupt for three machine timings: 48K, 128K and Pentagon.
- Mode is selectable at runtime and only takes effect at a frame boundary, so it never glitches the TV.
- Sits between the ULA pixel pipeline (colour in) and the video DAC/scan doubler (colour and sync out).

Parameters:
- CW, 3, bits per colour channel.
- HW, 9, horizontal counter width.
- VW, 9, vertical counter width.
- INT_LEN, 32, frame interrupt pulse length in clk cycles (1..255).

Ports:
- clk  in  1  pixel clock (7 MHz class).
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  requested timing: 00=48K, 01=128K, 10=Pentagon, 11=reserved (treated as 48K).
- ri, gi, bi  in  CW each  pixel colour, aligned with the current hcnt/vcnt.
- hcnt  out  HW  horizontal counter (registered).
- vcnt  out  VW  vertical counter (registered).
- ro, go, bo  out  CW each  blanked colour, registered.
- hsync  out  1  active-low horizontal sync, registered.
- vsync  out  1  active-low vertical sync, registered.
- csync  out  1  active-low composite sync (hsync AND vsync), registered.
- int_n  out  1  active-low frame interrupt, registered.
- frame_start  out  1  one-cycle strobe when hc=0 and vc=0.
- active_mode  out  2  mode currently in effect.

Behaviour:
- Reset (async): hc=0, vc=0, active_mode=00, ro/go/bo=0, hsync=vsync=csync=int_n=1, frame_start=0.
- Per-mode line/frame ends:
  - 48K: HEND=447, VEND=311.
  - 128K: HEND=455, VEND=310.
  - Pentagon: HEND=447, VEND=319.
  - Reserved: same as 48K.
- Counters: hc increments every clk. At hc==HEND, hc goes to 0 and vc increments. If that happens with vc==VEND, vc goes to 0.
- Mode latch: active_mode takes the value of mode only in the cycle where hc==HEND and vc==VEND. The new ends apply from the next cycle. A mode change mid-frame has no effect until then.
- Counter overshoot: if hc>HEND or vc>VEND (counter beyond the end value), treat the count as wrap-to-0 on the next increment. This guarantees recovery.
- Horizontal timing, all modes: HBLANK 320..415, HSYNC 344..375 (inclusive).
- Vertical timing:
  - 48K and 128K: VBLANK 248..255, VSYNC 248..251.
  - Pentagon: VBLANK 240..255, VSYNC 240..243.
- Outputs are computed from the current hc/vc and registered, so they have 1 cycle latency relative to hcnt/vcnt.
- Colour: ro/go/bo equal ri/gi/bi, except 0 inside HBLANK or VBLANK.
- Sync gating: hsync and vsync are low only within their windows AND while blanked. csync is low when either sync is low.
- Interrupt: int_n is low while vc == the first VSYNC line and hc < INT_LEN, in every mode. INT_LEN > HEND+1 clamps to the end of the line.
- frame_start is registered from (hc==0 && vc==0) and has the same 1-cycle latency as the other outputs.
- Reset asserted mid-frame: everything returns to the reset values immediately. Counting resumes from 0,0 on the first clk after release.

Test Plan:
- Reset, mode=00, run 2 frames -> frame_start period 448*312=139776 cycles. hsync low 32 cycles per line. vsync low 4 lines. int_n low 32 cycles at vc=248, hc 0..31.
- mode=01 from reset -> first frame still 139776 cycles (48K). From the second frame, period 456*311=141816 and active_mode=01.
- mode=10 -> after the boundary, period 448*320=143360. vsync low for vc 240..243. Colour forced to 0 for vc 240..255.
- Toggle mode 00->01->00 mid-frame, several times -> no change to active_mode or period until the frame end. Only the value present at the boundary takes effect.
- ri=gi=bi=7 constant -> ro=7 at hcnt=319 (seen one cycle later). ro=0 for hcnt 320..415. ro=7 at hcnt 416. csync low exactly when hsync or vsync is low.
- Assert rst at hc=200, vc=100 for 3 cycles -> all outputs take the reset values asynchronously. hcnt=1 on the first clk edge after release. mode=11 then behaves identically to 48K.
